// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, shift, rotate, load and clear operations.
// A start pulse runs a burst of nshift steps that stalls while en is low.
module univ_shift_reg #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] D,
  input  logic             sin_r,
  input  logic             sin_l,
  input  logic             start,
  input  logic [CNT_W-1:0] nshift,
  output logic [WIDTH-1:0] Q,
  output logic             sout_r,
  output logic             sout_l,
  output logic             busy,
  output logic             done
);

  typedef enum logic {
    S_IDLE,
    S_BURST
  } state_e;

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_SHR  = 3'b001;
  localparam logic [2:0] M_SHL  = 3'b010;
  localparam logic [2:0] M_ROR  = 3'b011;
  localparam logic [2:0] M_ROL  = 3'b100;
  localparam logic [2:0] M_LOAD = 3'b101;
  localparam logic [2:0] M_CLR  = 3'b110;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       burst_mode_q, burst_mode_d;
  logic             done_q, done_d;

  logic step_mode;
  logic start_burst;
  logic last_step;

  function automatic logic [WIDTH-1:0] apply_op(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] cur,
    input logic [WIDTH-1:0] din,
    input logic             sr,
    input logic             sl
  );
    logic [WIDTH-1:0] res;
    res = cur;
    case (op)
      M_HOLD: res = cur;
      M_SHR:  res = {sr, cur[WIDTH-1:1]};
      M_SHL:  res = {cur[WIDTH-2:0], sl};
      M_ROR:  res = {cur[0], cur[WIDTH-1:1]};
      M_ROL:  res = {cur[WIDTH-2:0], cur[WIDTH-1]};
      M_LOAD: res = din;
      M_CLR:  res = '0;
      default: res = cur;
    endcase
    return res;
  endfunction

  assign step_mode   = (mode >= M_SHR) && (mode <= M_ROL);
  assign start_burst = start && (nshift != '0) && step_mode;
  assign last_step   = (cnt_q == CNT_ONE);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      q_q          <= '0;
      cnt_q        <= '0;
      burst_mode_q <= M_HOLD;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      q_q          <= q_d;
      cnt_q        <= cnt_d;
      burst_mode_q <= burst_mode_d;
      done_q       <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (en && start_burst && (nshift != CNT_ONE)) begin
          state_d = S_BURST;
        end
      end
      S_BURST: begin
        if (en && last_step) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: the first burst step happens in the start cycle,
  // so the counter holds the steps still outstanding after it.
  always_comb begin
    q_d          = q_q;
    cnt_d        = cnt_q;
    burst_mode_d = burst_mode_q;
    done_d       = 1'b0;
    if (en) begin
      if (state_q == S_BURST) begin
        q_d    = apply_op(burst_mode_q, q_q, D, sin_r, sin_l);
        cnt_d  = cnt_q - CNT_ONE;
        done_d = last_step;
      end else if (start_burst) begin
        q_d          = apply_op(mode, q_q, D, sin_r, sin_l);
        burst_mode_d = mode;
        cnt_d        = nshift - CNT_ONE;
        done_d       = (nshift == CNT_ONE);
      end else begin
        q_d = apply_op(mode, q_q, D, sin_r, sin_l);
      end
    end
  end

  // Outputs
  always_comb begin
    Q      = q_q;
    sout_r = q_q[0];
    sout_l = q_q[WIDTH-1];
    busy   = (state_q == S_BURST);
    done   = done_q;
  end

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg: the driver queues expected outputs,
// a negedge monitor pops and compares them cycle by cycle.
module tb_univ_shift_reg;

  logic       clk;
  logic       rst;
  logic       en;
  logic [2:0] mode;
  logic [7:0] D;
  logic       sin_r;
  logic       sin_l;
  logic       start;
  logic [3:0] nshift;
  logic [7:0] Q;
  logic       sout_r;
  logic       sout_l;
  logic       busy;
  logic       done;

  univ_shift_reg #(
    .WIDTH(8),
    .CNT_W(4)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .mode  (mode),
    .D     (D),
    .sin_r (sin_r),
    .sin_l (sin_l),
    .start (start),
    .nshift(nshift),
    .Q     (Q),
    .sout_r(sout_r),
    .sout_l(sout_l),
    .busy  (busy),
    .done  (done)
  );

  typedef struct packed {
    logic [31:0] cyc;
    logic [31:0] id;
    logic [7:0]  q;
    logic        busy;
    logic        done;
  } exp_t;

  exp_t sb[$];
  int   edge_cnt = 0;
  int   vid      = 0;
  int   checks   = 0;
  int   errors   = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) edge_cnt++;

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() != 0 && sb[0].cyc == edge_cnt) begin
      e = sb.pop_front();
      checks++;
      if (Q !== e.q || busy !== e.busy || done !== e.done ||
          sout_r !== e.q[0] || sout_l !== e.q[7]) begin
        errors++;
        $display("FAIL vec%0d: got Q=%h busy=%b done=%b sr=%b sl=%b, want Q=%h busy=%b done=%b",
                 e.id, Q, busy, done, sout_r, sout_l, e.q, e.busy, e.done);
      end
    end
  end

  task automatic drv(
    input logic       r,
    input logic       e,
    input logic [2:0] m,
    input logic [7:0] d,
    input logic       sr,
    input logic       sl,
    input logic       st,
    input logic [3:0] ns,
    input logic [7:0] eq,
    input logic       eb,
    input logic       ed
  );
    exp_t x;
    rst    = r;
    en     = e;
    mode   = m;
    D      = d;
    sin_r  = sr;
    sin_l  = sl;
    start  = st;
    nshift = ns;
    vid++;
    x.cyc  = 32'(edge_cnt + 1);
    x.id   = 32'(vid);
    x.q    = eq;
    x.busy = eb;
    x.done = ed;
    sb.push_back(x);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset wins over a load request and over en=0
    drv(1, 1, 3'b101, 8'hFF, 0, 0, 1, 4'd3, 8'h00, 0, 0);
    drv(1, 0, 3'b000, 8'h00, 0, 0, 0, 4'd0, 8'h00, 0, 0);
    // load then rotate right
    drv(0, 1, 3'b101, 8'hA5, 0, 0, 0, 4'd0, 8'hA5, 0, 0);
    drv(0, 1, 3'b011, 8'h00, 0, 0, 0, 4'd0, 8'hD2, 0, 0);
    // start with nshift=0 is a plain load
    drv(0, 1, 3'b101, 8'h3C, 0, 0, 1, 4'd0, 8'h3C, 0, 0);
    // en=0 with clear keeps Q
    drv(0, 0, 3'b110, 8'h00, 0, 0, 0, 4'd0, 8'h3C, 0, 0);
    drv(0, 1, 3'b110, 8'h00, 0, 0, 0, 4'd0, 8'h00, 0, 0);
    // single shifts and rotate left
    drv(0, 1, 3'b101, 8'h81, 0, 0, 0, 4'd0, 8'h81, 0, 0);
    drv(0, 1, 3'b001, 8'h00, 0, 0, 0, 4'd0, 8'h40, 0, 0);
    drv(0, 1, 3'b010, 8'h00, 0, 1, 0, 4'd0, 8'h81, 0, 0);
    drv(0, 1, 3'b100, 8'h00, 0, 0, 0, 4'd0, 8'h03, 0, 0);
    drv(0, 1, 3'b111, 8'h00, 1, 1, 0, 4'd0, 8'h03, 0, 0);
    // rotate-left burst of 3 from 81
    drv(0, 1, 3'b101, 8'h81, 0, 0, 0, 4'd0, 8'h81, 0, 0);
    drv(0, 1, 3'b100, 8'h00, 0, 0, 1, 4'd3, 8'h03, 1, 0);
    drv(0, 1, 3'b101, 8'hFF, 0, 0, 1, 4'd7, 8'h06, 1, 0);
    drv(0, 1, 3'b110, 8'h00, 0, 0, 0, 4'd0, 8'h0C, 0, 1);
    drv(0, 1, 3'b000, 8'h00, 0, 0, 0, 4'd0, 8'h0C, 0, 0);
    // shift-right burst of 4 with a 2-cycle stall
    drv(0, 1, 3'b110, 8'h00, 0, 0, 0, 4'd0, 8'h00, 0, 0);
    drv(0, 1, 3'b001, 8'h00, 1, 0, 1, 4'd4, 8'h80, 1, 0);
    drv(0, 1, 3'b000, 8'h00, 1, 0, 0, 4'd0, 8'hC0, 1, 0);
    drv(0, 0, 3'b000, 8'h00, 0, 0, 0, 4'd0, 8'hC0, 1, 0);
    drv(0, 0, 3'b110, 8'h00, 0, 0, 1, 4'd0, 8'hC0, 1, 0);
    drv(0, 1, 3'b000, 8'h00, 1, 0, 0, 4'd0, 8'hE0, 1, 0);
    drv(0, 1, 3'b000, 8'h00, 1, 0, 0, 4'd0, 8'hF0, 0, 1);
    drv(0, 1, 3'b000, 8'h00, 1, 0, 0, 4'd0, 8'hF0, 0, 0);
    // back-to-back bursts: second start in the done cycle
    drv(0, 1, 3'b010, 8'h00, 0, 1, 1, 4'd2, 8'hE1, 1, 0);
    drv(0, 1, 3'b000, 8'h00, 0, 1, 0, 4'd0, 8'hC3, 0, 1);
    drv(0, 1, 3'b011, 8'h00, 0, 0, 1, 4'd2, 8'hE1, 1, 0);
    drv(0, 1, 3'b000, 8'h00, 0, 0, 0, 4'd0, 8'hF0, 0, 1);
    drv(0, 1, 3'b000, 8'h00, 0, 0, 0, 4'd0, 8'hF0, 0, 0);
    // single-step burst pulses done with no busy
    drv(0, 1, 3'b001, 8'h00, 0, 0, 1, 4'd1, 8'h78, 0, 1);
    drv(0, 1, 3'b000, 8'h00, 0, 0, 0, 4'd0, 8'h78, 0, 0);
    // reset in cycle 2 of a 5-step burst
    drv(0, 1, 3'b010, 8'h00, 0, 0, 1, 4'd5, 8'hF0, 1, 0);
    drv(1, 1, 3'b000, 8'h00, 0, 0, 0, 4'd0, 8'h00, 0, 0);
    drv(0, 1, 3'b000, 8'h00, 0, 0, 0, 4'd0, 8'h00, 0, 0);
    drv(0, 1, 3'b000, 8'h00, 0, 0, 0, 4'd0, 8'h00, 0, 0);
    // maximum-length rotate left wraps modulo 8
    drv(0, 1, 3'b101, 8'h01, 0, 0, 0, 4'd0, 8'h01, 0, 0);
    drv(0, 1, 3'b100, 8'h00, 0, 0, 1, 4'd15, 8'h02, 1, 0);
    for (int i = 2; i <= 15; i++)
      drv(0, 1, 3'b000, 8'h00, 0, 0, 0, 4'd0,
          8'(1 << (i % 8)), i < 15, i == 15);
    drv(0, 1, 3'b000, 8'h00, 0, 0, 0, 4'd0, 8'h80, 0, 0);
    // maximum-length shift left fills with sin_l
    drv(0, 1, 3'b110, 8'h00, 0, 0, 0, 4'd0, 8'h00, 0, 0);
    drv(0, 1, 3'b010, 8'h00, 0, 1, 1, 4'd15, 8'h01, 1, 0);
    for (int i = 2; i <= 15; i++)
      drv(0, 1, 3'b000, 8'h00, 0, 1, 0, 4'd0,
          (i >= 8) ? 8'hFF : 8'((1 << i) - 1), i < 15, i == 15);
    drv(0, 1, 3'b000, 8'h00, 0, 0, 0, 4'd0, 8'hFF, 0, 0);

    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
